// File: rtl/quad_steer_pkg.sv
// quad_steer_pkg: shared types, Gray constants and helpers for the
// quadrature steering generator.
package quad_steer_pkg;

   localparam logic [1:0] GRAY_0 = 2'b00;
   localparam logic [1:0] GRAY_1 = 2'b01;
   localparam logic [1:0] GRAY_2 = 2'b11;
   localparam logic [1:0] GRAY_3 = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INC  = 2'd1,
      DEC  = 2'd2
   } dir_t;

   typedef logic [1:0] level_t;

   // |v| with -128 folded onto 127 so the result always fits 7 bits
   function automatic logic [6:0] sat_mag(input logic signed [7:0] v);
      logic [7:0] neg;
      neg = -v;
      if (v == -8'sd128) return 7'd127;
      if (v[7])          return neg[6:0];
      return v[6:0];
   endfunction

   // One Gray step forward (INC) or backward (DEC); IDLE holds the state
   function automatic logic [1:0] gray_step(input logic [1:0] s, input dir_t d);
      logic [1:0] fwd;
      logic [1:0] bwd;
      case (s)
         GRAY_0:  begin fwd = GRAY_1; bwd = GRAY_3; end
         GRAY_1:  begin fwd = GRAY_2; bwd = GRAY_0; end
         GRAY_2:  begin fwd = GRAY_3; bwd = GRAY_1; end
         default: begin fwd = GRAY_0; bwd = GRAY_2; end
      endcase
      if (d == INC) return fwd;
      if (d == DEC) return bwd;
      return s;
   endfunction

endpackage

// File: rtl/quad_steer_gen_ch.sv
// quad_steer_ch: one quadrature channel. Decodes buttons/stick into a
// direction and speed level, divides clk_sys down to a step rate, walks a
// Gray A/B state and auto-selects against a synchronised external encoder.
// Optional build macro: QUAD_ACCEL_EN adds the hold-to-accelerate ramp for
// digital presses; without it digital presses always run at level 0.
module quad_steer_ch
   import quad_steer_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int CLKDIV      = 5500,
   parameter int ACCEL_STEPS = 16,
   parameter int DEADZONE    = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              left_i,
   input  logic              right_i,
   input  logic signed [7:0] analog_i,
   input  logic              analog_en_i,
   input  logic              ext_a_i,
   input  logic              ext_b_i,
   output logic              enc_a_o,
   output logic              enc_b_o,
   output logic              ext_active_o
);

   localparam logic [DIV_W-1:0] BASE_PERIOD = DIV_W'(CLKDIV);
   localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);

   dir_t             dir_d, dir_q;
   logic             use_analog;
   logic [6:0]       mag;
   level_t           lvl;
   logic [DIV_W-1:0] period, cnt_eff, cnt_d, cnt_q;
   logic             step;
   logic [1:0]       gray_d, gray_q;
   logic [1:0]       sync1_q, sync2_q, prev_q;
   logic             ext_active_d, ext_active_q;
   logic [1:0]       enc_d, enc_q;

   // Direction decode: a single pressed button wins, otherwise the stick
   always_comb begin
      mag        = sat_mag(analog_i);
      use_analog = 1'b0;
      dir_d      = IDLE;
      if (right_i && !left_i) begin
         dir_d = INC;
      end else if (left_i && !right_i) begin
         dir_d = DEC;
      end else if (analog_en_i && (int'(mag) >= DEADZONE)) begin
         use_analog = 1'b1;
         dir_d      = analog_i[7] ? DEC : INC;
      end
   end

`ifdef QUAD_ACCEL_EN
   localparam int            RW        = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;
   localparam logic [RW-1:0] RAMP_LAST = RW'(ACCEL_STEPS - 1);

   logic          ramp_cont;
   logic          dig_d, dig_q;
   level_t        ramp_lvl_eff, ramp_lvl_d, ramp_lvl_q;
   logic [RW-1:0] ramp_cnt_eff, ramp_cnt_d, ramp_cnt_q;

   // Ramp history only survives while the same digital press continues
   always_comb begin
      ramp_cont    = dig_q && !use_analog && (dir_d != IDLE) && (dir_d == dir_q);
      ramp_lvl_eff = ramp_cont ? ramp_lvl_q : 2'd0;
      ramp_cnt_eff = ramp_cont ? ramp_cnt_q : '0;
   end

   // Count digital steps; every ACCEL_STEPS of them raises the level up to 3
   always_comb begin
      ramp_lvl_d = ramp_lvl_eff;
      ramp_cnt_d = ramp_cnt_eff;
      dig_d      = (dir_d != IDLE) && !use_analog;
      if (step && !use_analog) begin
         if (ramp_cnt_eff == RAMP_LAST) begin
            ramp_cnt_d = '0;
            if (ramp_lvl_eff != 2'd3) ramp_lvl_d = ramp_lvl_eff + 2'd1;
         end else begin
            ramp_cnt_d = ramp_cnt_eff + RW'(1);
         end
      end
   end

   // Ramp state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dig_q      <= 1'b0;
         ramp_lvl_q <= 2'd0;
         ramp_cnt_q <= '0;
      end else begin
         dig_q      <= dig_d;
         ramp_lvl_q <= ramp_lvl_d;
         ramp_cnt_q <= ramp_cnt_d;
      end
   end

   assign lvl = use_analog ? level_t'(mag[6:5]) : ramp_lvl_eff;
`else
   assign lvl = use_analog ? level_t'(mag[6:5]) : 2'd0;
`endif

   // Step divider: a new or reversed direction restarts the count from 0,
   // and a period that shrank below the count fires on the next cycle
   always_comb begin
      period  = BASE_PERIOD >> lvl;
      cnt_eff = (dir_d != dir_q) ? '0 : cnt_q;
      step    = (dir_d != IDLE) && (cnt_eff >= (period - ONE));
      cnt_d   = ((dir_d == IDLE) || step) ? '0 : (cnt_eff + ONE);
      gray_d  = step ? gray_step(gray_q, dir_d) : gray_q;
   end

   // Source select: external motion claims the output, a generated step
   // takes it back and wins a same-cycle tie
   always_comb begin
      ext_active_d = ext_active_q;
      if (sync2_q != prev_q) ext_active_d = 1'b1;
      if (step)              ext_active_d = 1'b0;
      enc_d = ext_active_d ? sync2_q : gray_q;
   end

   // Channel state, synchroniser and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dir_q        <= IDLE;
         cnt_q        <= '0;
         gray_q       <= GRAY_0;
         sync1_q      <= 2'b00;
         sync2_q      <= 2'b00;
         prev_q       <= 2'b00;
         ext_active_q <= 1'b0;
         enc_q        <= 2'b00;
      end else begin
         dir_q        <= dir_d;
         cnt_q        <= cnt_d;
         gray_q       <= gray_d;
         sync1_q      <= {ext_a_i, ext_b_i};
         sync2_q      <= sync1_q;
         prev_q       <= sync2_q;
         ext_active_q <= ext_active_d;
         enc_q        <= enc_d;
      end
   end

   assign enc_a_o      = enc_q[1];
   assign enc_b_o      = enc_q[0];
   assign ext_active_o = ext_active_q;

endmodule

// File: rtl/quad_steer_gen.sv
// quad_steer_gen: multi-channel quadrature encoder synthesiser. Slices the
// vector ports and instantiates one independent quad_steer_ch per channel.
// Optional build macro: QUAD_ACCEL_EN (hold-to-accelerate for digital input).
module quad_steer_gen
   import quad_steer_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int DIV_W       = 16,
   parameter int CLKDIV      = 5500,
   parameter int ACCEL_STEPS = 16,
   parameter int DEADZONE    = 8
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic [CHANNELS-1:0]   left,
   input  logic [CHANNELS-1:0]   right,
   input  logic [8*CHANNELS-1:0] analog,
   input  logic [CHANNELS-1:0]   analog_en,
   input  logic [CHANNELS-1:0]   ext_a,
   input  logic [CHANNELS-1:0]   ext_b,
   output logic [CHANNELS-1:0]   enc_a,
   output logic [CHANNELS-1:0]   enc_b,
   output logic [CHANNELS-1:0]   ext_active
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      quad_steer_ch #(
         .DIV_W      (DIV_W),
         .CLKDIV     (CLKDIV),
         .ACCEL_STEPS(ACCEL_STEPS),
         .DEADZONE   (DEADZONE)
      ) u_ch (
         .clk_i       (clk_sys),
         .rst_ni      (reset_n),
         .left_i      (left[i]),
         .right_i     (right[i]),
         .analog_i    (analog[8*i +: 8]),
         .analog_en_i (analog_en[i]),
         .ext_a_i     (ext_a[i]),
         .ext_b_i     (ext_b[i]),
         .enc_a_o     (enc_a[i]),
         .enc_b_o     (enc_b[i]),
         .ext_active_o(ext_active[i])
      );
   end

endmodule

// File: tb/tb_quad_steer_gen.sv
// tb_quad_steer_gen: directed and randomized bench for quad_steer_gen with a
// behavioural per-channel model (position counter, elapsed-time rate rule,
// delayed external pin history). Honours QUAD_ACCEL_EN when defined.
module tb_quad_steer_gen;
   localparam int CH    = 2;
   localparam int DIV_W = 16;
   localparam int CLKD  = 8;
   localparam int ACCEL = 4;
   localparam int DZ    = 8;

   logic              clk_sys = 1'b0;
   logic              reset_n;
   logic [CH-1:0]     left, right, analog_en, ext_a, ext_b;
   logic [8*CH-1:0]   analog;
   logic [CH-1:0]     enc_a, enc_b, ext_active;

   int total = 0;
   int bad   = 0;

   always #5 clk_sys = ~clk_sys;

   quad_steer_gen #(
      .CHANNELS(CH), .DIV_W(DIV_W), .CLKDIV(CLKD), .ACCEL_STEPS(ACCEL), .DEADZONE(DZ)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .left(left), .right(right),
      .analog(analog), .analog_en(analog_en), .ext_a(ext_a), .ext_b(ext_b),
      .enc_a(enc_a), .enc_b(enc_b), .ext_active(ext_active)
   );

   // ---------------- behavioural model ----------------
   int         pos[CH];        // signed step position, Gray index = pos mod 4
   int         run_dir[CH];    // -1/0/+1 seen on the previous edge
   int         elapsed[CH];    // cycles spent since the run or last step started
   int         run_steps[CH];  // steps taken in the current digital run
   logic [1:0] hist[CH][3];    // ext pins seen 1, 2 and 3 edges ago
   logic       m_act[CH];
   logic [1:0] m_enc[CH];

   function automatic logic [1:0] gray_of(input int p);
      int i;
      i = ((p % 4) + 4) % 4;
      case (i)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic int idx_of(input logic [1:0] g);
      case (g)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         pos[c] = 0; run_dir[c] = 0; elapsed[c] = 0; run_steps[c] = 0;
         m_act[c] = 1'b0; m_enc[c] = 2'b00;
         for (int k = 0; k < 3; k++) hist[c][k] = 2'b00;
      end
   endtask

   task automatic model_edge(input int c);
      int d, lvl, per, mag, old_pos;
      bit an, fire;
      logic signed [7:0] av;
      av = analog[8*c +: 8];
      d = 0; an = 0; lvl = 0; fire = 0;
      if (right[c] && !left[c]) d = 1;
      else if (left[c] && !right[c]) d = -1;
      else if (analog_en[c]) begin
         mag = (av < 0) ? -int'(av) : int'(av);
         if (mag > 127) mag = 127;
         if (mag >= DZ) begin
            d = (av < 0) ? -1 : 1;
            an = 1;
            lvl = mag / 32;
         end
      end
      if (d == 0 || an) run_steps[c] = 0;
      if (d != run_dir[c]) begin
         elapsed[c] = 0;
         run_steps[c] = 0;
      end
`ifdef QUAD_ACCEL_EN
      if (!an && d != 0) begin
         lvl = run_steps[c] / ACCEL;
         if (lvl > 3) lvl = 3;
      end
`endif
      per = CLKD >> lvl;
      old_pos = pos[c];
      if (d != 0) begin
         if (elapsed[c] + 1 >= per) begin
            fire = 1;
            pos[c] += d;
            elapsed[c] = 0;
            if (!an) run_steps[c]++;
         end else begin
            elapsed[c]++;
         end
      end
      run_dir[c] = d;
      if (fire) m_act[c] = 1'b0;
      else if (hist[c][1] != hist[c][2]) m_act[c] = 1'b1;
      m_enc[c] = m_act[c] ? hist[c][1] : gray_of(old_pos);
      hist[c][2] = hist[c][1];
      hist[c][1] = hist[c][0];
      hist[c][0] = {ext_a[c], ext_b[c]};
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk_sys or negedge reset_n);
         if (!reset_n) model_reset();
         else for (int c = 0; c < CH; c++) model_edge(c);
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk_sys);
         for (int c = 0; c < CH; c++) begin
            chk($sformatf("model_enc_ch%0d", c), 32'({enc_a[c], enc_b[c]}), 32'(m_enc[c]));
            chk($sformatf("model_act_ch%0d", c), 32'(ext_active[c]), 32'(m_act[c]));
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #2;
   endtask

   function automatic logic [1:0] enc_of(input int c);
      return {enc_a[c], enc_b[c]};
   endfunction

   // Edges until channel c's output changes; -1 if it never does within maxe
   task automatic edges_to_change(input int c, input int maxe, output int n);
      logic [1:0] start;
      start = enc_of(c);
      n = 0;
      while (n < maxe) begin
         @(posedge clk_sys);
         #1;
         n++;
         if (enc_of(c) != start) break;
      end
      if (enc_of(c) == start) n = -1;
   endtask

   task automatic hold_check(input int c, input int cycles, input string name);
      logic [1:0] start;
      start = enc_of(c);
      tick(cycles);
      chk(name, 32'(enc_of(c)), 32'(start));
   endtask

   function automatic int exp_gap(input int k);
`ifdef QUAD_ACCEL_EN
      if (k <= 4) return 8;
      if (k <= 8) return 4;
      if (k <= 12) return 2;
      return 1;
`else
      if (k > 0) return 8;
      return 0;
`endif
   endfunction

   function automatic logic [7:0] pick_analog();
      logic [7:0] v;
      case ($urandom_range(0, 3))
         0: v = 8'($urandom);
         1: v = 8'h80;
         2: v = 8'($urandom_range(0, 18)) - 8'd9;
         default: begin
            v = 8'($urandom_range(30, 127));
            if ($urandom_range(0, 1) == 1) v = -v;
         end
      endcase
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      logic [1:0] prev;
      logic [1:0] seq [4];
      seq = '{2'b00, 2'b01, 2'b11, 2'b10};
      reset_n = 1'b0;
      left = '0; right = '0; analog_en = '0; ext_a = '0; ext_b = '0; analog = '0;
      tick(3);
      chk("rst_enc", 32'({enc_a, enc_b}), 32'd0);
      chk("rst_ext_active", 32'(ext_active), 32'd0);
      reset_n = 1'b1;
      tick(2);

      // Digital press on ch0
      right[0] = 1'b1;
      edges_to_change(0, 20, n);
      chk("first_step_edges", n, 9);
      chk("first_step_val", 32'(enc_of(0)), 32'(2'b01));
      for (int k = 2; k <= 14; k++) begin
         edges_to_change(0, 20, n);
         chk($sformatf("gap_step%0d", k), n, exp_gap(k));
         if (k <= 4) chk($sformatf("val_step%0d", k), 32'(enc_of(0)), 32'(seq[k % 4]));
      end
      chk("ch1_idle", 32'(enc_of(1)), 32'd0);

      // Release and re-press in the other direction: back to full period
      tick(1);
      right[0] = 1'b0;
      tick(4);
      prev = enc_of(0);
      left[0] = 1'b1;
      edges_to_change(0, 20, n);
      chk("repress_first", n, 9);
      chk("repress_retreat", 32'(enc_of(0)), 32'(gray_of(idx_of(prev) - 1)));
      edges_to_change(0, 20, n);
      chk("repress_gap", n, 8);
      tick(1);
      left[0] = 1'b0;

      // Analog on ch1: +100 -> level 3 (period 1)
      analog[15:8] = 8'd100;
      analog_en[1] = 1'b1;
      edges_to_change(1, 20, n);
      chk("analog_first", n, 2);
      chk("analog_val1", 32'(enc_of(1)), 32'(2'b01));
      edges_to_change(1, 20, n);
      chk("analog_gap", n, 1);
      chk("analog_val2", 32'(enc_of(1)), 32'(2'b11));
      tick(1);
      analog[15:8] = 8'hFB;           // -5: inside dead zone
      tick(3);
      hold_check(1, 20, "deadzone_hold");
      prev = enc_of(1);
      analog[15:8] = 8'h80;           // -128: saturates to 127, decrements
      edges_to_change(1, 20, n);
      chk("neg128_first", n, 2);
      chk("neg128_retreat", 32'(enc_of(1)), 32'(gray_of(idx_of(prev) - 1)));
      tick(1);
      analog_en[1] = 1'b0;
      analog[15:8] = 8'd0;

      // Conflict on ch0: both buttons, analog disabled then +40
      tick(3);
      left[0] = 1'b1; right[0] = 1'b1;
      hold_check(0, 30, "conflict_hold");
      prev = enc_of(0);
      analog[7:0] = 8'd40;
      analog_en[0] = 1'b1;
      edges_to_change(0, 20, n);
      chk("conflict_analog_first", n, 5);
      chk("conflict_analog_val", 32'(enc_of(0)), 32'(gray_of(idx_of(prev) + 1)));
      tick(1);
      left[0] = 1'b0; right[0] = 1'b0; analog_en[0] = 1'b0; analog[7:0] = 8'd0;
      tick(3);

      // External encoder takeover on ch1
      ext_a[1] = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      chk("ext_not_yet", 32'(ext_active[1]), 32'd0);
      @(posedge clk_sys);
      #1;
      chk("ext_active_3cyc", 32'(ext_active[1]), 32'd1);
      chk("ext_enc_follow", 32'(enc_of(1)), 32'(2'b10));
      tick(2);

      // Generated steps every cycle beat a simultaneous external change
      analog[15:8] = 8'd100;
      analog_en[1] = 1'b1;
      ext_b[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_sys);
         #1;
         chk($sformatf("step_wins_%0d", k), 32'(ext_active[1]), 32'd0);
      end
      #1;
      analog_en[1] = 1'b0;
      analog[15:8] = 8'd0;
      tick(3);

      // Reset while stepping at state 11
      right[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         edges_to_change(0, 20, n);
         if (enc_of(0) == 2'b11) break;
      end
      chk("reach_11", 32'(enc_of(0)), 32'(2'b11));
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_enc", 32'({enc_a, enc_b}), 32'd0);
      chk("midrst_ext_active", 32'(ext_active), 32'd0);
      tick(2);
      reset_n = 1'b1;
      edges_to_change(0, 20, n);
      chk("post_rst_first", n, 9);
      chk("post_rst_val", 32'(enc_of(0)), 32'(2'b01));
      tick(1);
      right[0] = 1'b0;
      ext_a = '0; ext_b = '0;
      tick(5);

      // Randomized phase, checked every cycle by the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk_sys);
         #2;
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 19) == 0) begin
               left[c]      = ($urandom_range(0, 2) == 0);
               right[c]     = ($urandom_range(0, 2) == 0);
               analog_en[c] = ($urandom_range(0, 1) == 1);
               analog[8*c +: 8] = pick_analog();
            end
            if ($urandom_range(0, 49) == 0) ext_a[c] = ~ext_a[c];
            if ($urandom_range(0, 49) == 0) ext_b[c] = ~ext_b[c];
         end
         if ($urandom_range(0, 999) == 0) begin
            reset_n = 1'b0;
            #2;
            reset_n = 1'b1;
         end
      end

      tick(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
